// File: rtl/a51_lfsr_core_if.sv
// Phase-flag, key/frame and keystream signals between the A5/1 phase counter side
// and the LFSR core.
interface a51_lfsr_core_if #(
  parameter int KEY_W    = 64,
  parameter int FRAME_W  = 22,
  parameter int OUT_BITS = 224
);
  logic                ENABLE;
  logic                STAGEONE;
  logic                STAGETWO;
  logic                STAGETHREE;
  logic                OUTPUTSTAGE;
  logic                DONE;
  logic [KEY_W-1:0]    KEY;
  logic [FRAME_W-1:0]  FRAME;
  logic                KSBIT;
  logic                KSVALID;
  logic [OUT_BITS-1:0] KSWORD;
  logic                READY;

  modport master (
    output ENABLE, STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE, KEY, FRAME,
    input  KSBIT, KSVALID, KSWORD, READY
  );

  modport slave (
    input  ENABLE, STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE, KEY, FRAME,
    output KSBIT, KSVALID, KSWORD, READY
  );
endinterface

// File: rtl/a51_lfsr_core.sv
// A5/1 keystream generator: three LFSRs driven by the phase flags of the
// upstream counter, one keystream bit per output cycle, accumulated into KSWORD.
module a51_lfsr_core #(
  parameter int KEY_W    = 64,
  parameter int FRAME_W  = 22,
  parameter int OUT_BITS = 224
) (
  input logic               C,
  input logic               CLR,
  a51_lfsr_core_if.slave    bus
);
  localparam int KI_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int FI_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int OC_W = $clog2(OUT_BITS + 1);
  localparam logic [KI_W-1:0] KI_LAST = KI_W'(KEY_W - 1);
  localparam logic [FI_W-1:0] FI_LAST = FI_W'(FRAME_W - 1);
  localparam logic [OC_W-1:0] OC_MAX  = OC_W'(OUT_BITS);

  logic [18:0]         r1, n_r1;
  logic [21:0]         r2, n_r2;
  logic [22:0]         r3, n_r3;
  logic [KI_W-1:0]     kidx, n_kidx;
  logic [FI_W-1:0]     fidx, n_fidx;
  logic [OC_W-1:0]     ocnt, n_ocnt;
  logic                ksbit, n_ksbit;
  logic                ksvalid, n_ksvalid;
  logic [OUT_BITS-1:0] ksword, n_ksword;
  logic                ready, n_ready;
  logic                prev_load, n_prev_load;
  logic                maj;

  function automatic logic [18:0] clk1(input logic [18:0] r, input logic in);
    return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18] ^ in};
  endfunction

  function automatic logic [21:0] clk2(input logic [21:0] r, input logic in);
    return {r[20:0], r[20] ^ r[21] ^ in};
  endfunction

  function automatic logic [22:0] clk3(input logic [22:0] r, input logic in);
    return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22] ^ in};
  endfunction

  assign maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);

  always_comb begin
    n_r1        = r1;
    n_r2        = r2;
    n_r3        = r3;
    n_kidx      = kidx;
    n_fidx      = fidx;
    n_ocnt      = ocnt;
    n_ksbit     = ksbit;
    n_ksvalid   = 1'b0;
    n_ksword    = ksword;
    n_ready     = ready;
    n_prev_load = prev_load;
    if (bus.ENABLE) begin
      n_prev_load = 1'b0;
      if (bus.STAGEONE) begin
        // First key cycle after anything else starts a fresh sequence.
        if (!prev_load) begin
          n_r1     = '0;
          n_r2     = '0;
          n_r3     = '0;
          n_kidx   = '0;
          n_fidx   = '0;
          n_ocnt   = '0;
          n_ksword = '0;
          n_ready  = 1'b0;
        end
        n_r1        = clk1(n_r1, bus.KEY[n_kidx]);
        n_r2        = clk2(n_r2, bus.KEY[n_kidx]);
        n_r3        = clk3(n_r3, bus.KEY[n_kidx]);
        n_kidx      = (n_kidx == KI_LAST) ? '0 : n_kidx + 1'b1;
        n_prev_load = 1'b1;
      end else if (bus.STAGETWO) begin
        n_r1   = clk1(r1, bus.FRAME[fidx]);
        n_r2   = clk2(r2, bus.FRAME[fidx]);
        n_r3   = clk3(r3, bus.FRAME[fidx]);
        n_fidx = (fidx == FI_LAST) ? '0 : fidx + 1'b1;
      end else if (bus.STAGETHREE) begin
        if (r1[8] == maj) n_r1 = clk1(r1, 1'b0);
        if (r2[10] == maj) n_r2 = clk2(r2, 1'b0);
        if (r3[10] == maj) n_r3 = clk3(r3, 1'b0);
      end else if (bus.OUTPUTSTAGE) begin
        if (ocnt < OC_MAX) begin
          if (r1[8] == maj) n_r1 = clk1(r1, 1'b0);
          if (r2[10] == maj) n_r2 = clk2(r2, 1'b0);
          if (r3[10] == maj) n_r3 = clk3(r3, 1'b0);
          n_ksbit   = n_r1[18] ^ n_r2[21] ^ n_r3[22];
          n_ksvalid = 1'b1;
          n_ksword  = {ksword[OUT_BITS-2:0], n_ksbit};
          n_ocnt    = ocnt + 1'b1;
          if (n_ocnt == OC_MAX) n_ready = 1'b1;
        end
      end else if (bus.DONE) begin
        n_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      kidx      <= '0;
      fidx      <= '0;
      ocnt      <= '0;
      ksbit     <= 1'b0;
      ksvalid   <= 1'b0;
      ksword    <= '0;
      ready     <= 1'b0;
      prev_load <= 1'b0;
    end else begin
      r1        <= n_r1;
      r2        <= n_r2;
      r3        <= n_r3;
      kidx      <= n_kidx;
      fidx      <= n_fidx;
      ocnt      <= n_ocnt;
      ksbit     <= n_ksbit;
      ksvalid   <= n_ksvalid;
      ksword    <= n_ksword;
      ready     <= n_ready;
      prev_load <= n_prev_load;
    end
  end

  assign bus.KSBIT   = ksbit;
  assign bus.KSVALID = ksvalid;
  assign bus.KSWORD  = ksword;
  assign bus.READY   = ready;
endmodule

// File: tb/tb_a51_lfsr_core.sv
// Bench for a51_lfsr_core: drives the phase-counter sequence and checks the
// keystream against an arithmetic A5/1 reference computed per run.
module tb_a51_lfsr_core;
  logic C = 1'b0;
  logic CLR = 1'b1;
  always #5 C = ~C;

  a51_lfsr_core_if #(.KEY_W(64), .FRAME_W(22), .OUT_BITS(224)) bus ();
  a51_lfsr_core #(.KEY_W(64), .FRAME_W(22), .OUT_BITS(224)) dut (.C(C), .CLR(CLR), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit exp_kv = 1'b0;
  bit exp_ready = 1'b0;
  int out_n = 0;
  bit exp_q[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference register step: shift left, LSB = parity of tapped bits ^ input.
  function automatic longint lclk(input longint r, input int i, input bit in);
    longint tap;
    int len;
    bit fb;
    case (i)
      0:       begin tap = 64'h72000;  len = 19; end
      1:       begin tap = 64'h300000; len = 22; end
      default: begin tap = 64'h700080; len = 23; end
    endcase
    fb = (^(r & tap)) ^ in;
    return ((r << 1) | longint'(fb)) & ((longint'(1) << len) - 1);
  endfunction

  function automatic logic [223:0] golden(input logic [63:0] k, input logic [21:0] f);
    longint r[3];
    int cb[3];
    logic [223:0] w;
    bit c0, c1, c2, m;
    cb = '{8, 10, 10};
    r = '{0, 0, 0};
    w = '0;
    for (int i = 0; i < 64; i++) for (int j = 0; j < 3; j++) r[j] = lclk(r[j], j, k[i]);
    for (int i = 0; i < 22; i++) for (int j = 0; j < 3; j++) r[j] = lclk(r[j], j, f[i]);
    for (int i = 0; i < 100 + 224; i++) begin
      c0 = r[0][cb[0]]; c1 = r[1][cb[1]]; c2 = r[2][cb[2]];
      m = (c0 & c1) | (c0 & c2) | (c1 & c2);
      if (c0 == m) r[0] = lclk(r[0], 0, 1'b0);
      if (c1 == m) r[1] = lclk(r[1], 1, 1'b0);
      if (c2 == m) r[2] = lclk(r[2], 2, 1'b0);
      if (i >= 100) w[223 - (i - 100)] = r[0][18] ^ r[1][21] ^ r[2][22];
    end
    return w;
  endfunction

  task automatic step(input bit en, input bit s1, input bit s2, input bit s3, input bit so, input bit dn);
    bus.ENABLE = en; bus.STAGEONE = s1; bus.STAGETWO = s2;
    bus.STAGETHREE = s3; bus.OUTPUTSTAGE = so; bus.DONE = dn;
    @(posedge C);
    #1;
    exp_kv = 1'b0;
    if (en) begin
      if (s1) begin
        exp_ready = 1'b0;
        out_n = 0;
      end else if (!s2 && !s3 && so) begin
        if (out_n < 224) begin
          exp_kv = 1'b1;
          out_n++;
          if (out_n == 224) exp_ready = 1'b1;
        end
      end else if (!s2 && !s3 && dn) begin
        exp_ready = 1'b1;
      end
    end
  endtask

  always @(negedge C) begin
    if (mon_en) begin
      chk("ksvalid", bus.KSVALID, exp_kv);
      chk("ready", bus.READY, exp_ready);
      if (bus.KSVALID) begin
        chk("ksbit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("ksbit", bus.KSBIT, exp_q.pop_front());
      end
    end
  end

  // One full counter sequence; optional stalls, key/mix overlap on the first
  // edge, and an asynchronous clear after abort_at output cycles.
  task automatic run(input logic [63:0] k, input logic [21:0] f, input bit stall,
                     input bit overlap, input int abort_at);
    logic [223:0] w;
    w = golden(k, f);
    exp_q.delete();
    for (int i = 0; i < 224; i++) exp_q.push_back(w[223 - i]);
    bus.KEY = k;
    bus.FRAME = f;
    for (int i = 0; i < 64; i++) begin
      step(1, 1, 0, overlap && i == 0, 0, 0);
      if (i == 0 && k == 64'h1) begin
        chk("r1_first_key", 256'(dut.r1), 1);
        chk("r2_first_key", 256'(dut.r2), 1);
        chk("r3_first_key", 256'(dut.r3), 1);
      end
    end
    for (int i = 0; i < 22; i++) step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      if (stall && i == 50) repeat (5) step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 224; i++) begin
      if (i == abort_at) begin
        mon_en = 1'b0;
        #2 CLR = 1'b1;
        #1;
        chk("clr_ksbit", bus.KSBIT, 0);
        chk("clr_ksvalid", bus.KSVALID, 0);
        chk("clr_ksword", bus.KSWORD, 0);
        chk("clr_ready", bus.READY, 0);
        exp_kv = 1'b0; exp_ready = 1'b0; out_n = 0;
        exp_q.delete();
        @(posedge C);
        #1 CLR = 1'b0;
        mon_en = 1'b1;
        return;
      end
      if (stall && i == 100) repeat (5) step(0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
    end
    repeat (2) step(1, 0, 0, 0, 1, 0);
    repeat (4) step(1, 0, 0, 0, 0, 1);
    chk("ksword", bus.KSWORD, w);
    chk("ks_count", exp_q.size(), 0);
  endtask

  initial begin
    logic [63:0] rk;
    bus.ENABLE = 0; bus.STAGEONE = 0; bus.STAGETWO = 0; bus.STAGETHREE = 0;
    bus.OUTPUTSTAGE = 0; bus.DONE = 0; bus.KEY = '0; bus.FRAME = '0;
    repeat (2) @(posedge C);
    #1;
    chk("rst_ksbit", bus.KSBIT, 0);
    chk("rst_ksvalid", bus.KSVALID, 0);
    chk("rst_ksword", bus.KSWORD, 0);
    chk("rst_ready", bus.READY, 0);
    CLR = 1'b0;

    chk("model_r1_tap18", lclk(64'h40000, 0, 1'b0), 64'h1);
    chk("model_r1_tap13", lclk(64'h2000, 0, 1'b0), 64'h4001);
    chk("model_r2_tap20", lclk(64'h100000, 1, 1'b1), 64'h200000);
    chk("model_zero", golden(64'h0, 22'h0), 0);
    mon_en = 1'b1;

    run(64'h0, 22'h0, 0, 0, -1);
    chk("r1_zero", 256'(dut.r1), 0);
    chk("r2_zero", 256'(dut.r2), 0);
    chk("r3_zero", 256'(dut.r3), 0);

    repeat (3) step(1, 0, 0, 0, 0, 0);
    run(64'h1, 22'h134, 0, 1, -1);

    repeat (3) step(1, 0, 0, 0, 0, 0);
    rk = {$urandom, $urandom};
    run(rk, 22'($urandom), 1, 0, -1);

    repeat (3) step(1, 0, 0, 0, 0, 0);
    run(64'h0123_4567_89AB_CDEF, 22'h2F1A5, 0, 0, -1);

    run(64'hDEAD_BEEF_CAFE_F00D, 22'h15A5A, 0, 0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/a51_lfsr_core.md
Name: a51_lfsr_core

Overview:
- Keystream generator for the A5/1 datapath. Sits directly downstream of the A5/1 phase counter and consumes its registered phase flags (STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE) and its ENABLE.
- Each phase flag selects one operation on the three A5/1 LFSRs: key load, frame load, mixing, or keystream output.
- Produces one keystream bit per output cycle and accumulates the full keystream word for the XOR encrypt/decrypt stage.

Parameters:
- KEY_W, 64, session key width; key bits are loaded KEY[0] first.
- FRAME_W, 22, frame number width; frame bits are loaded FRAME[0] first.
- OUT_BITS, 224, number of keystream bits collected into KSWORD.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- CLR  input  1  asynchronous active-high reset.
- ENABLE  input  1  advance enable; same signal that drives the phase counter.
- STAGEONE  input  1  key-load phase flag.
- STAGETWO  input  1  frame-load phase flag.
- STAGETHREE  input  1  mixing (discard) phase flag.
- OUTPUTSTAGE  input  1  keystream output phase flag.
- DONE  input  1  sequence-complete flag.
- KEY  input  KEY_W  session key.
- FRAME  input  FRAME_W  frame number.
- KSBIT  output  1  current keystream bit, registered.
- KSVALID  output  1  KSBIT is valid this cycle.
- KSWORD  output  OUT_BITS  accumulated keystream; first bit ends at the MSB after OUT_BITS shifts.
- READY  output  1  KSWORD complete; held high.

Behaviour:
- Registers: R1 19b, R2 22b, R3 23b.
  - Feedback: f1=R1[13]^R1[16]^R1[17]^R1[18]; f2=R2[20]^R2[21]; f3=R3[7]^R3[20]^R3[21]^R3[22].
  - Clocking a register means shift left by one, with the new LSB = feedback ^ input bit.
  - Clock bits are R1[8], R2[10], R3[10]; maj = majority of the three.
- CLR high (async) forces: R1=R2=R3=0, kidx=0, fidx=0, ocnt=0, KSBIT=0, KSVALID=0, KSWORD=0, READY=0, prev_load=0. CLR dominates all other inputs.
- ENABLE=0: all state holds; KSVALID=0 on the next edge.
- Each edge with ENABLE=1, flags evaluated in priority order STAGEONE > STAGETWO > STAGETHREE > OUTPUTSTAGE > DONE:
  - STAGEONE:
    - If prev_load=0 (first key cycle), registers, indices, ocnt, KSWORD and READY are treated as zero before this edge's load.
    - All three registers clock with input KEY[kidx]; then kidx++ (mod KEY_W); prev_load=1.
  - STAGETWO: all three registers clock with input FRAME[fidx]; fidx++ (mod FRAME_W); prev_load=0.
  - STAGETHREE: majority clocking with input 0 (register i clocks iff its clock bit == maj); KSVALID=0.
  - OUTPUTSTAGE, ocnt<OUT_BITS:
    - Majority clocking.
    - KSBIT = R1[18]^R2[21]^R3[22], computed on the post-clock values.
    - KSVALID=1; KSWORD = {KSWORD[OUT_BITS-2:0], KSBIT}; ocnt++.
    - READY=1 when ocnt reaches OUT_BITS.
  - OUTPUTSTAGE, ocnt==OUT_BITS: no register or KSWORD change; KSVALID=0.
  - DONE: registers hold; READY=1; KSVALID=0.
  - No flag high (counter not yet started): hold; KSVALID=0.
- Latency and alignment:
  - Phase flags and KSBIT are registered, so KSVALID is high in the cycle after each OUTPUTSTAGE edge.
  - The first KSVALID follows the first OUTPUTSTAGE edge.
  - With the default counter, 64 key + 22 frame + 100 mix cycles precede output.
- Restart: a STAGEONE cycle following any non-STAGEONE cycle (e.g. after counter clear) restarts cleanly without asserting CLR. READY drops on that edge.
- Multiple flags high is an upstream fault; the priority above decides. No error output.
- Widths: ocnt is $clog2(OUT_BITS+1) bits; kidx and fidx are wide enough for KEY_W and FRAME_W and wrap.

Test Plan:
- CLR pulse asserted mid-OUTPUTSTAGE, asynchronous to C -> all outputs 0 immediately, before the next edge; READY=0.
- KEY=0, FRAME=0, full 410-cycle run -> R1/R2/R3 stay 0; 224 KSVALID pulses, all KSBIT=0; KSWORD=0; READY=1 held during DONE.
- KEY=64'h1 (KEY[0]=1), first STAGEONE edge -> R1=1, R2=1, R3=1; run to completion; KSWORD bit-exact against the team A5/1 golden model.
- Full run with random KEY/FRAME, ENABLE deasserted for 5 cycles mid-STAGETHREE and mid-OUTPUTSTAGE -> KSWORD identical to the run without stalls; KSVALID=0 throughout each stall.
- Complete one run, then counter clear and a second run with a different KEY -> READY drops on the first STAGEONE edge; KSWORD matches the golden model for the second key (no residue from the first run).
- STAGEONE and STAGETHREE high together for one cycle -> registers regular-clock with KEY[kidx] (key-load priority); KSVALID=0.
